// File: rtl/addsub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// The carry chain is cut into equal chunks, one chunk per pipeline stage.
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } flags_t;

    // Bits resolved per stage; a zero stage count falls back to one chunk.
    function automatic int chunk_count(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline stage: ripples a CHUNK-bit slice of the sum using the carry
// from the previous stage, and forwards the operands and partial sum.
module addsub_stage
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_bp,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_bp,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK:0]   chunk_res;
    logic [WIDTH-1:0] sum_nxt;

    // Bubble-collapsing: an empty stage always loads, a full one only when drained.
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        chunk_res = {1'b0, in_a[LO +: CHUNK]} + {1'b0, in_bp[LO +: CHUNK]}
                  + {{CHUNK{1'b0}}, in_c};
        sum_nxt = in_sum;
        sum_nxt[LO +: CHUNK] = chunk_res[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_bp    <= '0;
            out_sum   <= '0;
            out_c     <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_a   <= in_a;
                out_bp  <= in_bp;
                out_sum <= sum_nxt;
                out_c   <= chunk_res[CHUNK];
            end
        end
    end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub with valid/ready on both sides.
// Flags are derived from the last stage's registered operands and sum.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK = chunk_count(WIDTH, STAGES);

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_addsub: WIDTH must be a positive multiple of STAGES");
    end

    op_e                          op;
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:0]              rdy_pipe;
    logic [STAGES:0][WIDTH-1:0]   a_pipe;
    logic [STAGES:0][WIDTH-1:0]   bp_pipe;
    logic [STAGES:0][WIDTH-1:0]   sum_pipe;
    logic [STAGES:0]              c_pipe;
    flags_t                       flg;
    logic                         unused_bits;

    // Operand B and the carry-in are conditioned once, before the chain.
    assign op          = op_e'(sub);
    assign vld_pipe[0] = in_valid;
    assign a_pipe[0]   = a;
    assign bp_pipe[0]  = (op == OP_SUB) ? ~b : b;
    assign sum_pipe[0] = '0;
    assign c_pipe[0]   = cin ^ (op == OP_SUB);

    assign in_ready         = rdy_pipe[0];
    assign rdy_pipe[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_pipe[k]),
            .in_ready  (rdy_pipe[k]),
            .in_a      (a_pipe[k]),
            .in_bp     (bp_pipe[k]),
            .in_sum    (sum_pipe[k]),
            .in_c      (c_pipe[k]),
            .out_valid (vld_pipe[k+1]),
            .out_ready (rdy_pipe[k+1]),
            .out_a     (a_pipe[k+1]),
            .out_bp    (bp_pipe[k+1]),
            .out_sum   (sum_pipe[k+1]),
            .out_c     (c_pipe[k+1])
        );
    end

    always_comb begin
        flg.cout = c_pipe[STAGES];
        flg.ovf  = (a_pipe[STAGES][WIDTH-1] == bp_pipe[STAGES][WIDTH-1]) &&
                   (sum_pipe[STAGES][WIDTH-1] != a_pipe[STAGES][WIDTH-1]);
        flg.zero = ~|sum_pipe[STAGES];
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = sum_pipe[STAGES];
    assign cout      = flg.cout;
    assign ovf       = flg.ovf;
    assign zero      = flg.zero;

    // Only the operand sign bits matter after the last stage.
    assign unused_bits = ^{a_pipe[STAGES], bp_pipe[STAGES]};

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides.
- The WIDTH-bit carry chain is split into STAGES equal chunks. Each chunk is registered, so the critical path is one CHUNK-bit ripple.
- Used as the arithmetic building block for datapaths that need an adder wider or faster than a single-cycle ripple allows.
- Produces sum, carry-out, signed overflow and zero flags.

Parameters:
- WIDTH, 32: operand/result width in bits; must be at least 1.
- STAGES, 4: number of pipeline stages (carry-chain chunks); 1 <= STAGES <= WIDTH, and WIDTH % STAGES == 0 (elaboration-time assertion).
- CHUNK, WIDTH/STAGES: derived localparam; bits resolved per stage.

Ports:
- clk  in  1  clock; all flops are rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for sub.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of the MSB; in sub mode, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Arithmetic, modulo 2^WIDTH: sum = a + (b ^ {WIDTH{sub}}) + (cin ^ sub).
  - sub=0: a+b+cin.
  - sub=1, cin=0: a-b.
  - sub=1, cin=1: a-b-1 (cin acts as borrow-in).
- Let b' = b ^ {WIDTH{sub}}.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
  - cout = bit WIDTH of the full-width sum.
  - zero = ~|sum.
- Pipeline structure:
  - Stage k (0..STAGES-1) resolves bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1; stage 0 uses cin^sub.
  - Unresolved upper operand bits (already conditioned by sub) travel with the beat.
  - Resolved lower sum bits are carried forward.
- Each stage has a valid flop. Stage k may load when !valid_k || ready_{k+1}; the last stage may load when !out_valid || out_ready.
- in_ready = !valid_0 || ready_1. This is a combinational ready chain (bubble-collapsing); no skid buffers are required.
- Latency: exactly STAGES cycles from an accepted input to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Outputs sum/cout/ovf/zero are driven from the last stage register. zero is computed combinationally from the registered sum. They must hold stable while out_valid && !out_ready.
- Beats are never dropped, duplicated or reordered.
- A beat presented while in_ready=0 is not taken; the upstream must hold a/b/cin/sub stable until accepted.
- STAGES == 1: single registered stage, latency 1.
- STAGES == WIDTH: one bit per stage.
- Reset (asynchronous assert, synchronous deassert is the integrator's responsibility):
  - All valid flags clear; out_valid=0.
  - sum=0, cout=0, ovf=0, zero=1 (follows sum=0).
  - in_ready=1 from the first cycle after reset deasserts.
- Reset mid-stream discards all in-flight beats; no partial results are emitted afterwards.
- Data flops may be left without reset. Outputs must still read as above whenever out_valid=0 after reset, so the sum register is reset.

Decomposition:
- Shared package (addsub_pkg):
  - op_e enum {OP_ADD=0, OP_SUB=1}.
  - A flags struct {cout, ovf, zero}.
  - Helper function chunk_count(width, stages).
- Sub-module addsub_stage: one registered pipeline stage holding a CHUNK-bit ripple chunk, its valid flop and its local ready logic. It is instantiated STAGES times in a generate loop.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, sum=0, zero=1 throughout; in_ready=1 on the first cycle after release.
- Single add: a=0xFFFF_FFFF, b=0x0000_0001, cin=0, sub=0 -> exactly 4 cycles later out_valid=1, sum=0, cout=1, zero=1, ovf=0.
- Subtract with borrow and overflow: a=0x8000_0000, b=1, sub=1, cin=0 -> sum=0x7FFF_FFFF, cout=1, ovf=1. Then a=5, b=5, sub=1, cin=1 -> sum=0xFFFF_FFFF, cout=0, zero=0.
- Streaming: 100 back-to-back random beats with out_ready=1 -> 100 results in order, one per cycle, each matching a scoreboard model.
- Backpressure: random out_ready at 30% duty against continuous in_valid -> no loss/duplication; outputs stable while stalled; in_ready falls once all 4 stages are full.
- Corner configs: rebuild with STAGES=1 and STAGES=32 -> latencies 1 and 32; a reset pulse mid-stream flushes the pipeline and no stale beat appears afterwards.
